triangle_setup_seq: RTL and testbench

- Sequential, parametrised triangle-setup engine for the primitive-assembly stage.
- Accepts one screen-space triangle of signed QF fixed-point vertices over a valid/ready handshake.
- Computes three edge equations and the signed doubled area; culls back/front faces by mode, drops degenerates, and derives the reciprocal of the doubled area with an iterative restoring divider.
- Emits the result on a valid/ready output toward the rasteriser; one triangle in flight.

---
 rtl/triangle_setup_seq.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_triangle_setup_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_setup_seq.sv
// triangle_setup_seq: sequential triangle-setup engine for primitive assembly.
// Captures one screen-space triangle, forms its three edge equations and the
// signed doubled area, drops degenerate or culled faces, then derives the
// reciprocal 2^(3F)/S with a restoring divider that resolves one quotient bit
// per cycle. Exactly one triangle is in flight at a time.
module triangle_setup_seq #(
  parameter int W  = 32,
  parameter int F  = 16,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   x0,
  input  logic signed [W-1:0]   y0,
  input  logic signed [W-1:0]   x1,
  input  logic signed [W-1:0]   y1,
  input  logic signed [W-1:0]   x2,
  input  logic signed [W-1:0]   y2,
  input  logic [1:0]            cull_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W:0]     a0,
  output logic signed [W:0]     a1,
  output logic signed [W:0]     a2,
  output logic signed [W:0]     b0,
  output logic signed [W:0]     b1,
  output logic signed [W:0]     b2,
  output logic signed [2*W:0]   c0,
  output logic signed [2*W:0]   c1,
  output logic signed [2*W:0]   c2,
  output logic signed [2*W+2:0] area2,
  output logic signed [W-1:0]   recip,
  output logic                  recip_sat,
  output logic [CW-1:0]         cull_count,
  output logic [CW-1:0]         degen_count
);

  // Quotient bits: numerator 2^(3F) needs 3F+1 bits, one bit per DIV cycle.
  localparam int QW = 3*F + 1;
  // Doubled-area width; |S| also fits in SW unsigned bits.
  localparam int SW = 2*W + 3;
  // Shifted partial remainder needs one bit above the divisor.
  localparam int RW = SW + 1;
  // Quotient widened so the saturation test can always look at bits >= W-1.
  localparam int XW = (QW > W) ? QW : W;
  localparam int NW = $clog2(QW);
  localparam logic [NW-1:0] LAST_STEP = NW'(QW - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CHECK,
    DIV,
    OUT
  } state_t;

  state_t state_q, state_d;

  // Handshake / control strobes decoded by the FSM.
  logic accept, do_setup, do_degen, do_cull, do_load, do_step, div_last;

  // Captured triangle.
  logic signed [W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
  logic [1:0]          mode_q;

  // Setup arithmetic on the captured vertices.
  logic signed [W:0]    a0_c, a1_c, a2_c, b0_c, b1_c, b2_c;
  logic signed [2*W:0]  c0_c, c1_c, c2_c;
  logic signed [SW-1:0] s_c;

  // Face classification of the registered area.
  logic          area_zero, area_neg, cull_hit;
  logic [SW-1:0] area_mag;

  // Restoring divider state and next-state terms.
  logic [QW-1:0] num_q, quo_q, quo_nx;
  logic [SW-1:0] rem_q, div_q, rem_nx;
  logic [RW-1:0] rem_sh;
  logic [NW-1:0] cnt_q;
  logic          neg_q, q_bit, sat_nx;
  logic [XW-1:0] quo_ext;
  logic [W-1:0]  mag_nx, recip_nx;

  // p - q, sign-extended one bit so it can never overflow.
  function automatic logic signed [W:0] diff_w(input logic signed [W-1:0] p,
                                               input logic signed [W-1:0] q);
    return $signed({p[W-1], p}) - $signed({q[W-1], q});
  endfunction

  // xa*ya - xb*yb with full-width products and no truncation.
  function automatic logic signed [2*W:0] cross_w(input logic signed [W-1:0] xa,
                                                  input logic signed [W-1:0] ya,
                                                  input logic signed [W-1:0] xb,
                                                  input logic signed [W-1:0] yb);
    logic signed [2*W-1:0] pa, pb;
    pa = $signed({{W{xa[W-1]}}, xa}) * $signed({{W{ya[W-1]}}, ya});
    pb = $signed({{W{xb[W-1]}}, xb}) * $signed({{W{yb[W-1]}}, yb});
    return $signed({pa[2*W-1], pa}) - $signed({pb[2*W-1], pb});
  endfunction

  // One x*(dy) term of the doubled area, extended to the area width.
  function automatic logic signed [SW-1:0] area_term(input logic signed [W-1:0] xv,
                                                     input logic signed [W:0]   dy);
    logic signed [2*W:0] p;
    p = $signed({{(W+1){xv[W-1]}}, xv}) * $signed({{W{dy[W]}}, dy});
    return $signed({{2{p[2*W]}}, p});
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    do_setup  = 1'b0;
    do_degen  = 1'b0;
    do_cull   = 1'b0;
    do_load   = 1'b0;
    do_step   = 1'b0;
    div_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        do_setup = 1'b1;
        state_d  = CHECK;
      end
      CHECK: begin
        if (area_zero) begin
          do_degen = 1'b1;
          state_d  = IDLE;
        end else if (cull_hit) begin
          do_cull = 1'b1;
          state_d = IDLE;
        end else begin
          do_load = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        do_step = 1'b1;
        if (cnt_q == LAST_STEP) begin
          div_last = 1'b1;
          state_d  = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge equations and doubled area of the captured triangle.
  always_comb begin
    a0_c = diff_w(vy1, vy0);
    b0_c = diff_w(vx0, vx1);
    c0_c = cross_w(vx1, vy0, vx0, vy1);
    a1_c = diff_w(vy2, vy1);
    b1_c = diff_w(vx1, vx2);
    c1_c = cross_w(vx2, vy1, vx1, vy2);
    a2_c = diff_w(vy0, vy2);
    b2_c = diff_w(vx2, vx0);
    c2_c = cross_w(vx0, vy2, vx2, vy0);
    s_c  = area_term(vx0, diff_w(vy1, vy2))
         + area_term(vx1, diff_w(vy2, vy0))
         + area_term(vx2, diff_w(vy0, vy1));
  end

  // Classification: S>0 is CCW; mode 1 drops CW, mode 2 drops CCW.
  assign area_zero = (area2 == '0);
  assign area_neg  = area2[SW-1];
  assign cull_hit  = ((mode_q == 2'd1) && area_neg) ||
                     ((mode_q == 2'd2) && !area_neg);
  assign area_mag  = area_neg ? -area2 : area2;

  // One restoring step plus the final saturate/negate of the quotient.
  always_comb begin
    rem_sh   = {rem_q, num_q[QW-1]};
    q_bit    = (rem_sh >= {1'b0, div_q});
    rem_nx   = q_bit ? SW'(rem_sh - {1'b0, div_q}) : rem_sh[SW-1:0];
    quo_nx   = {quo_q[QW-2:0], q_bit};
    quo_ext  = XW'(quo_nx);
    sat_nx   = |quo_ext[XW-1:W-1];
    mag_nx   = sat_nx ? {1'b0, {(W-1){1'b1}}} : quo_ext[W-1:0];
    recip_nx = neg_q ? -mag_nx : mag_nx;
  end

  // Capture vertices and cull mode on the input handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vx0    <= '0;
      vy0    <= '0;
      vx1    <= '0;
      vy1    <= '0;
      vx2    <= '0;
      vy2    <= '0;
      mode_q <= '0;
    end else if (accept) begin
      vx0    <= x0;
      vy0    <= y0;
      vx1    <= x1;
      vy1    <= y1;
      vx2    <= x2;
      vy2    <= y2;
      mode_q <= cull_mode;
    end
  end

  // Register the setup results; they stay put through DIV and OUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a0    <= '0;
      a1    <= '0;
      a2    <= '0;
      b0    <= '0;
      b1    <= '0;
      b2    <= '0;
      c0    <= '0;
      c1    <= '0;
      c2    <= '0;
      area2 <= '0;
    end else if (do_setup) begin
      a0    <= a0_c;
      a1    <= a1_c;
      a2    <= a2_c;
      b0    <= b0_c;
      b1    <= b1_c;
      b2    <= b2_c;
      c0    <= c0_c;
      c1    <= c1_c;
      c2    <= c2_c;
      area2 <= s_c;
    end
  end

  // Saturating drop counters, updated on the CHECK edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cull_count  <= '0;
      degen_count <= '0;
    end else begin
      if (do_cull && (cull_count != '1))   cull_count  <= cull_count + CW'(1);
      if (do_degen && (degen_count != '1)) degen_count <= degen_count + CW'(1);
    end
  end

  // Divider: load 2^(3F) / |S| in CHECK, then shift out one bit per cycle.
  always_ff @(posedge clk) begin
    // NOTE: divider registers are reset too, so an aborted division leaves no
    // residue and the reciprocal outputs read zero straight out of reset.
    if (!rst_n) begin
      num_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else if (do_load) begin
      num_q <= {1'b1, {(QW-1){1'b0}}};
      rem_q <= '0;
      quo_q <= '0;
      div_q <= area_mag;
      neg_q <= area_neg;
      cnt_q <= '0;
    end else if (do_step) begin
      num_q <= {num_q[QW-2:0], 1'b0};
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + NW'(1);
    end
  end

  // Reciprocal output, latched on the last quotient bit and held through OUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      recip     <= '0;
      recip_sat <= 1'b0;
    end else if (div_last) begin
      recip     <= recip_nx;
      recip_sat <= sat_nx;
    end
  end

endmodule

// File: tb/tb_triangle_setup_seq.sv
// tb_triangle_setup_seq: directed bench for triangle_setup_seq. Emitted
// triangles are predicted by a wide-integer model into a scoreboard queue and
// compared when out_valid rises; drops are tracked with bench-side counters.
module tb_triangle_setup_seq;

  localparam int W     = 32;
  localparam int F     = 16;
  localparam int CW    = 6;
  localparam int LAT   = 3*F + 3;
  localparam int BOUND = 400;

  typedef struct {
    logic signed [W:0]     a0, a1, a2, b0, b1, b2;
    logic signed [2*W:0]   c0, c1, c2;
    logic signed [2*W+2:0] s;
    logic signed [W-1:0]   r;
    logic                  sat;
  } exp_t;

  logic                  clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic signed [W-1:0]   x0, y0, x1, y1, x2, y2;
  logic [1:0]            cull_mode;
  logic signed [W:0]     a0, a1, a2, b0, b1, b2;
  logic signed [2*W:0]   c0, c1, c2;
  logic signed [2*W+2:0] area2;
  logic signed [W-1:0]   recip;
  logic                  recip_sat;
  logic [CW-1:0]         cull_count, degen_count;

  int            n_checks = 0;
  int            n_fail   = 0;
  exp_t          sb[$];
  logic [CW-1:0] exp_cull, exp_degen;

  triangle_setup_seq #(.W(W), .F(F), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .x2         (x2),
    .y2         (y2),
    .cull_mode  (cull_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .b0         (b0),
    .b1         (b1),
    .b2         (b2),
    .c0         (c0),
    .c1         (c1),
    .c2         (c2),
    .area2      (area2),
    .recip      (recip),
    .recip_sat  (recip_sat),
    .cull_count (cull_count),
    .degen_count(degen_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain wide-integer arithmetic and a true division.
  function automatic exp_t model(input logic signed [W-1:0] px0, input logic signed [W-1:0] py0,
                                 input logic signed [W-1:0] px1, input logic signed [W-1:0] py1,
                                 input logic signed [W-1:0] px2, input logic signed [W-1:0] py2);
    logic signed [127:0] fx0, fy0, fx1, fy1, fx2, fy2, t, s;
    logic [127:0]        mag, q, lim, m, r;
    exp_t                e;
    fx0 = 128'(px0); fy0 = 128'(py0);
    fx1 = 128'(px1); fy1 = 128'(py1);
    fx2 = 128'(px2); fy2 = 128'(py2);
    t = fy1 - fy0;             e.a0 = t[W:0];
    t = fx0 - fx1;             e.b0 = t[W:0];
    t = fx1*fy0 - fx0*fy1;     e.c0 = t[2*W:0];
    t = fy2 - fy1;             e.a1 = t[W:0];
    t = fx1 - fx2;             e.b1 = t[W:0];
    t = fx2*fy1 - fx1*fy2;     e.c1 = t[2*W:0];
    t = fy0 - fy2;             e.a2 = t[W:0];
    t = fx2 - fx0;             e.b2 = t[W:0];
    t = fx0*fy2 - fx2*fy0;     e.c2 = t[2*W:0];
    s = fx0*(fy1 - fy2) + fx1*(fy2 - fy0) + fx2*(fy0 - fy1);
    e.s = s[2*W+2:0];
    e.r = '0;
    e.sat = 1'b0;
    if (s != 0) begin
      mag   = (s < 0) ? -s : s;
      q     = (128'd1 << (3*F)) / mag;
      lim   = (128'd1 << (W-1)) - 128'd1;
      e.sat = (q > lim);
      m     = e.sat ? lim : q;
      r     = (s < 0) ? -m : m;
      e.r   = r[W-1:0];
    end
    return e;
  endfunction

  // Present one triangle, wait for acceptance, and predict its fate.
  task automatic drive_tri(input logic signed [W-1:0] px0, input logic signed [W-1:0] py0,
                           input logic signed [W-1:0] px1, input logic signed [W-1:0] py1,
                           input logic signed [W-1:0] px2, input logic signed [W-1:0] py2,
                           input logic [1:0] m, output int kind);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1'b1);
    x0 = px0; y0 = py0; x1 = px1; y1 = py1; x2 = px2; y2 = py2;
    cull_mode = m;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    e = model(px0, py0, px1, py1, px2, py2);
    if (e.s == 0) begin
      kind = 2;
      if (exp_degen != '1) exp_degen++;
    end else if ((m == 2'd1 && e.s < 0) || (m == 2'd2 && e.s > 0)) begin
      kind = 1;
      if (exp_cull != '1) exp_cull++;
    end else begin
      kind = 0;
      sb.push_back(e);
    end
  endtask

  // A dropped triangle: busy for two cycles, ready again after edge k+2.
  task automatic expect_drop(input string tag);
    check({tag, "_busy_k"}, in_ready, 1'b0);
    @(negedge clk);
    check({tag, "_busy_k1"}, in_ready, 1'b0);
    @(negedge clk);
    check({tag, "_ready_k2"}, in_ready, 1'b1);
    check({tag, "_no_out"}, out_valid, 1'b0);
    check({tag, "_cull_count"}, cull_count, exp_cull);
    check({tag, "_degen_count"}, degen_count, exp_degen);
  endtask

  // Wait (bounded) for out_valid; cyc counts edges since the accept edge.
  task automatic wait_out(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_in_ready_low"}, in_ready, 1'b0);
  endtask

  task automatic compare_out(input string tag, output exp_t e);
    n_checks++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_scoreboard: observed empty queue expected one entry", tag);
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_a0"}, a0, e.a0);
    check({tag, "_a1"}, a1, e.a1);
    check({tag, "_a2"}, a2, e.a2);
    check({tag, "_b0"}, b0, e.b0);
    check({tag, "_b1"}, b1, e.b1);
    check({tag, "_b2"}, b2, e.b2);
    check({tag, "_c0"}, c0, e.c0);
    check({tag, "_c1"}, c1, e.c1);
    check({tag, "_c2"}, c2, e.c2);
    check({tag, "_area2"}, area2, e.s);
    check({tag, "_recip"}, recip, e.r);
    check({tag, "_recip_sat"}, recip_sat, e.sat);
  endtask

  // Hand-derived results of the unit triangle (0,0),(1.0,0),(0,1.0).
  task automatic check_unit(input string tag);
    check({tag, "_k_area2"}, area2, 67'sd4294967296);
    check({tag, "_k_recip"}, recip, 32'sh00010000);
    check({tag, "_k_sat"}, recip_sat, 1'b0);
    check({tag, "_k_a0"}, a0, 33'sd0);
    check({tag, "_k_b0"}, b0, -33'sd65536);
    check({tag, "_k_c0"}, c0, 65'sd0);
    check({tag, "_k_a1"}, a1, 33'sd65536);
    check({tag, "_k_b1"}, b1, 33'sd65536);
    check({tag, "_k_c1"}, c1, -65'sd4294967296);
    check({tag, "_k_a2"}, a2, -33'sd65536);
    check({tag, "_k_b2"}, b2, 33'sd0);
    check({tag, "_k_c2"}, c2, 65'sd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_recip"}, recip, 32'sd0);
    check({tag, "_recip_sat"}, recip_sat, 1'b0);
    check({tag, "_a1"}, a1, 33'sd0);
    check({tag, "_b0"}, b0, 33'sd0);
    check({tag, "_c1"}, c1, 65'sd0);
    check({tag, "_area2"}, area2, 67'sd0);
    check({tag, "_cull_count"}, cull_count, 6'd0);
    check({tag, "_degen_count"}, degen_count, 6'd0);
  endtask

  function automatic int rnd_small();
    return int'($urandom_range(0, 524288)) - 262144;
  endfunction

  initial begin
    int   kind;
    int   cyc;
    exp_t e;
    logic signed [W-1:0] rx[6];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cull_mode = 2'd0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    exp_cull = '0; exp_degen = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Unit CCW triangle, no culling: latency and exact coefficients.
    drive_tri(0, 0, 32'sh10000, 0, 0, 32'sh10000, 2'd0, kind);
    wait_out("unit", cyc);
    check("unit_latency", cyc, LAT);
    check_unit("unit");
    compare_out("unit", e);

    // Same triangle culled as CCW, then kept when only CW is culled.
    drive_tri(0, 0, 32'sh10000, 0, 0, 32'sh10000, 2'd2, kind);
    expect_drop("cull_ccw");
    drive_tri(0, 0, 32'sh10000, 0, 0, 32'sh10000, 2'd1, kind);
    wait_out("unit_m1", cyc);
    compare_out("unit_m1", e);

    // Collinear triangle is degenerate under every cull mode.
    for (int m = 0; m < 4; m++) begin
      drive_tri(0, 0, 32'sh10000, 32'sh10000, 32'sh20000, 32'sh20000, 2'(m), kind);
      expect_drop("collinear");
    end

    // |S| = 1: quotient far beyond range, saturates in both signs.
    drive_tri(0, 0, 1, 0, 0, 1, 2'd3, kind);
    wait_out("tiny_ccw", cyc);
    check("tiny_ccw_k_recip", recip, 32'sh7FFFFFFF);
    check("tiny_ccw_k_sat", recip_sat, 1'b1);
    check("tiny_ccw_k_area2", area2, 67'sd1);
    compare_out("tiny_ccw", e);
    drive_tri(0, 0, 0, 1, 1, 0, 2'd2, kind);
    wait_out("tiny_cw", cyc);
    check("tiny_cw_k_recip", recip, 32'sh80000001);
    check("tiny_cw_k_sat", recip_sat, 1'b1);
    check("tiny_cw_k_area2", area2, -67'sd1);
    compare_out("tiny_cw", e);

    // Full-range corners exercise the widest products.
    drive_tri(32'sh80000000, 32'sh80000000, 32'sh7FFFFFFF, 32'sh80000000,
              32'sh80000000, 32'sh7FFFFFFF, 2'd0, kind);
    wait_out("corner", cyc);
    compare_out("corner", e);

    // Pseudo-random triangles in small and full ranges, random cull mode.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 6; k++) rx[k] = (i < 5) ? rnd_small() : $signed($urandom());
      drive_tri(rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], 2'($urandom_range(0, 3)), kind);
      if (kind == 0) begin
        wait_out("rand", cyc);
        check("rand_latency", cyc, LAT);
        compare_out("rand", e);
      end else begin
        expect_drop("rand_drop");
      end
    end

    // Stall in OUT for 10 cycles with another triangle waiting at the input.
    out_ready = 1'b0;
    drive_tri(0, 0, 32'sh10000, 0, 0, 32'sh10000, 2'd0, kind);
    wait_out("stall", cyc);
    compare_out("stall", e);
    x0 = 0; y0 = 0; x1 = 32'sh30000; y1 = 0; x2 = 0; y2 = 32'sh50000;
    cull_mode = 2'd0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_recip", recip, e.r);
      check("stall_c1", c1, e.c1);
      check("stall_area2", area2, e.s);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_idle_ready", in_ready, 1'b1);
    check("b2b_idle_no_out", out_valid, 1'b0);
    sb.push_back(model(0, 0, 32'sh30000, 0, 0, 32'sh50000));
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accepted", in_ready, 1'b0);
    wait_out("b2b", cyc);
    check("b2b_latency", cyc, LAT);
    check("b2b_k_recip", recip, 32'sd4369);
    compare_out("b2b", e);

    // Reset pulse during DIV iteration 20 discards the triangle.
    drive_tri(0, 0, 32'sh10000, 0, 0, 32'sh10000, 2'd0, kind);
    repeat (22) @(negedge clk);
    check("middiv_busy", in_ready, 1'b0);
    check("middiv_no_out", out_valid, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e = sb.pop_back();
    exp_cull  = '0;
    exp_degen = '0;
    check_zero("middiv_reset");
    drive_tri(0, 0, 32'sh10000, 0, 0, 32'sh10000, 2'd0, kind);
    wait_out("after_reset", cyc);
    check("after_reset_latency", cyc, LAT);
    check_unit("after_reset");
    compare_out("after_reset", e);

    // Drive the cull counter past its maximum; it must stick at all-ones.
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      drive_tri(0, 0, 32'sh10000, 0, 0, 32'sh10000, 2'd2, kind);
      expect_drop("sat");
    end
    check("sat_cull_max", cull_count, {CW{1'b1}});
    check("sat_degen_untouched", degen_count, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
